prbs_checker: RTL

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker.sv | 135 +++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs_checker
// Purpose  : Lock/verify checker for a 4-bit LFSR stream, with error counting
//            and sync-loss detection. Optional macro PRBS_CHK_ZERO_DET_EN makes
//            an all-zero word in LOCKED drop lock immediately.
// Revision : 1.0
// ============================================================================
module prbs_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_Valid,
  input  logic [3:0]       In_Data,
  input  logic             Clr_Cnt,
  output logic             Locked,
  output logic             Err,
  output logic [CNT_W-1:0] Err_Cnt,
  output logic             Sync_Loss
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [3:0] lfsr_next(input logic [3:0] x);
    return {x[2:0], x[3] ^ x[2]};
  endfunction

  state_t             state, state_nxt;
  logic [3:0]         exp_word, exp_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt;
  logic [MISS_W-1:0]  miss_cnt, miss_nxt;
  logic               err_nxt;
  logic               sync_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               zero_hit;

`ifdef PRBS_CHK_ZERO_DET_EN
  assign zero_hit = (In_Data == 4'h0);
`else
  assign zero_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_word;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    err_nxt   = 1'b0;
    sync_nxt  = 1'b0;
    if (In_Valid) begin
      case (state)
        HUNT: begin
          if (In_Data != 4'h0) begin
            exp_nxt   = lfsr_next(In_Data);
            match_nxt = '0;
            state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          if (In_Data == exp_word) begin
            match_nxt = match_cnt + MATCH_W'(1);
            exp_nxt   = lfsr_next(exp_word);
            if ((match_cnt + MATCH_W'(1)) == MATCH_W'(LOCK_CNT)) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else begin
            state_nxt = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: expectation advances from itself, never from the line.
          exp_nxt = lfsr_next(exp_word);
          if (In_Data == exp_word) begin
            miss_nxt = '0;
          end else begin
            err_nxt = 1'b1;
            if (((miss_cnt + MISS_W'(1)) == MISS_W'(UNLOCK_CNT)) || zero_hit) begin
              state_nxt = HUNT;
              miss_nxt  = '0;
              sync_nxt  = 1'b1;
            end else begin
              miss_nxt = miss_cnt + MISS_W'(1);
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Clear wins over a same-cycle error; the Err pulse itself is unaffected.
  always_comb begin
    cnt_nxt = Err_Cnt;
    if (Clr_Cnt) begin
      cnt_nxt = '0;
    end else if (err_nxt && (Err_Cnt != {CNT_W{1'b1}})) begin
      cnt_nxt = Err_Cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= HUNT;
      exp_word  <= 4'h0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      Locked    <= 1'b0;
      Err       <= 1'b0;
      Err_Cnt   <= '0;
      Sync_Loss <= 1'b0;
    end else begin
      state     <= state_nxt;
      exp_word  <= exp_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      Locked    <= (state_nxt == LOCKED);
      Err       <= err_nxt;
      Err_Cnt   <= cnt_nxt;
      Sync_Loss <= sync_nxt;
    end
  end

endmodule
`default_nettype wire
